barrel_shift_arbiter: RTL and testbench

//   Shares one 32-bit barrel rotator (left/right rotate by 0..31) between two requesters.

---
 rtl/barrel_shift_arbiter.sv | 78 +++++++
 tb/tb_barrel_shift_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin shared 32-bit rotator with valid/ready request and response ports
module barrel_shift_arbiter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [2*WIDTH-1:0]   req_data,
   input  logic [2*SHAMT_W-1:0] req_amnt,
   input  logic [1:0]           req_dir,
   output logic [1:0]           resp_valid,
   input  logic [1:0]           resp_ready,
   output logic [WIDTH-1:0]     resp_data,
   output logic                 resp_id,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
   state_t state, state_nxt;
   logic last_grant, gnt_id, req_fire, resp_fire, op_dir, op_id;
   logic [WIDTH-1:0] op_data, rot;
   logic [SHAMT_W-1:0] op_amnt;
   logic [2*WIDTH-1:0] dbl_l, dbl_r;
   // grant: a lone requester always wins, the pointer only breaks ties
   always_comb begin
      gnt_id     = (&req_valid) ? ~last_grant : req_valid[1];
      req_ready  = (state == IDLE) ? (req_valid & (gnt_id ? 2'b10 : 2'b01)) : 2'b00;
      req_fire   = |(req_valid & req_ready);
      resp_valid = (state == RESP) ? (resp_id ? 2'b10 : 2'b01) : 2'b00;
      resp_fire  = (state == RESP) && resp_ready[resp_id];
      busy       = state != IDLE;
   end
   // rotate through a doubled word so amount 0 needs no special case
   always_comb begin
      dbl_l = {op_data, op_data} << op_amnt;
      dbl_r = {op_data, op_data} >> op_amnt;
      rot   = op_dir ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
   end
   // next state: IDLE -> SHIFT on accept, one SHIFT cycle, RESP until owner accepts
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = req_fire ? SHIFT : IDLE;
         SHIFT:   state_nxt = RESP;
         RESP:    state_nxt = resp_fire ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   // operand capture, result capture and round-robin pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         op_data    <= '0;
         op_amnt    <= '0;
         op_dir     <= 1'b0;
         op_id      <= 1'b0;
         resp_data  <= '0;
         resp_id    <= 1'b0;
      end else begin
         if (req_fire) begin
            op_data <= gnt_id ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
            op_amnt <= gnt_id ? req_amnt[2*SHAMT_W-1:SHAMT_W] : req_amnt[SHAMT_W-1:0];
            op_dir  <= req_dir[gnt_id];
            op_id   <= gnt_id;
         end
         if (state == SHIFT) begin
            resp_data <= rot;
            resp_id   <= op_id;
         end
         if (resp_fire) last_grant <= resp_id;
      end
   end
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: directed vector and corner-sequence bench for barrel_shift_arbiter
module tb_barrel_shift_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_valid = '0, req_ready, req_dir = '0, resp_valid, resp_ready = '0;
   logic [63:0] req_data = '0;
   logic [9:0]  req_amnt = '0;
   logic [31:0] resp_data;
   logic        resp_id, busy;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      logic        id;
      logic [31:0] d;
      logic [4:0]  a;
      logic        dir;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   barrel_shift_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_amnt(req_amnt), .req_dir(req_dir),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rot_ref(input logic [31:0] d, input int k, input logic left);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         if (left) r[(i + k) % 32] = d[i];
         else      r[i] = d[(i + k) % 32];
      return r;
   endfunction

   function automatic logic [1:0] onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

   task automatic set_port(input logic id, input logic [31:0] d, input logic [4:0] a, input logic dir);
      req_data[id*32 +: 32] = d;
      req_amnt[id*5 +: 5]   = a;
      req_dir[id]           = dir;
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      #2;
      chk("rst req_ready", {30'b0, req_ready}, 0);
      chk("rst resp_valid", {30'b0, resp_valid}, 0);
      chk("rst resp_data", resp_data, 0);
      chk("rst resp_id", {31'b0, resp_id}, 0);
      chk("rst busy", {31'b0, busy}, 0);
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic run_op(input logic id, input logic [31:0] d, input logic [4:0] a,
                         input logic dir, input logic [31:0] exp);
      @(negedge clk);
      set_port(id, d, a, dir);
      set_port(~id, $urandom, 5'($urandom), 1'($urandom));
      req_valid = onehot(id);
      #1 chk("op req_ready", {30'b0, req_ready}, {30'b0, onehot(id)});
      @(posedge clk) #1 req_valid = '0;
      chk("op shift busy", {31'b0, busy}, 1);
      chk("op shift resp_valid", {30'b0, resp_valid}, 0);
      set_port(~id, $urandom, 5'($urandom), 1'($urandom));
      @(posedge clk) #1;
      chk("op resp_valid", {30'b0, resp_valid}, {30'b0, onehot(id)});
      chk("op resp_data", resp_data, exp);
      chk("op resp_id", {31'b0, resp_id}, {31'b0, id});
      resp_ready = onehot(id);
      @(posedge clk) #1 resp_ready = '0;
      chk("op done resp_valid", {30'b0, resp_valid}, 0);
      chk("op done busy", {31'b0, busy}, 0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003};
      vecs[1] = '{1'b1, 32'h0000_0001, 5'd4,  1'b0, 32'h1000_0000};
      vecs[2] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
      vecs[4] = '{1'b0, 32'h1234_5678, 5'd8,  1'b1, 32'h3456_7812};
      vecs[5] = '{1'b1, 32'h1234_5678, 5'd8,  1'b0, 32'h7812_3456};
      vecs[6] = '{1'b0, 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000};
      vecs[7] = '{1'b1, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};

      do_reset();
      foreach (vecs[i]) run_op(vecs[i].id, vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].exp);

      // both requesters valid continuously: strict alternation, 3 cycles per op
      do_reset();
      set_port(1'b0, 32'h0000_00FF, 5'd4, 1'b1);
      set_port(1'b1, 32'h0000_00FF, 5'd4, 1'b0);
      resp_ready = 2'b11;
      req_valid  = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1 chk("rr req_ready", {30'b0, req_ready}, {30'b0, onehot(1'(k % 2))});
         @(posedge clk) #1 chk("rr shift busy", {31'b0, busy}, 1);
         @(posedge clk) #1;
         chk("rr resp_id", {31'b0, resp_id}, k % 2);
         chk("rr resp_data", resp_data, (k % 2) ? 32'hF000_000F : 32'h0000_0FF0);
         chk("rr resp req_ready", {30'b0, req_ready}, 0);
         @(posedge clk);
      end
      #1 req_valid = '0;
      resp_ready = '0;

      // stalled response: held stable, non-owner ready ignored, pending req1 waits
      do_reset();
      set_port(1'b0, 32'h8000_0001, 5'd1, 1'b1);
      set_port(1'b1, 32'h0000_0001, 5'd4, 1'b0);
      req_valid = 2'b11;
      #1 chk("stall first grant", {30'b0, req_ready}, 2'b01);
      @(posedge clk) #1 req_valid[0] = 1'b0;
      @(posedge clk) #1 resp_ready = 2'b10;
      for (int k = 0; k < 5; k++) begin
         chk("stall resp_valid", {30'b0, resp_valid}, 2'b01);
         chk("stall resp_data", resp_data, 32'h0000_0003);
         chk("stall req_ready", {30'b0, req_ready}, 0);
         @(posedge clk) #1;
      end
      resp_ready = 2'b01;
      chk("release same-cycle req_ready", {30'b0, req_ready}, 0);
      @(posedge clk) #1 resp_ready = '0;
      chk("release resp_valid", {30'b0, resp_valid}, 0);
      chk("pending req1 ready", {30'b0, req_ready}, 2'b10);
      @(posedge clk) #1 req_valid = '0;
      @(posedge clk) #1;
      chk("req1 resp_valid", {30'b0, resp_valid}, 2'b10);
      chk("req1 resp_data", resp_data, 32'h1000_0000);
      chk("req1 resp_id", {31'b0, resp_id}, 1);
      resp_ready = 2'b10;
      @(posedge clk) #1 resp_ready = '0;
      chk("req1 done busy", {31'b0, busy}, 0);

      // async reset during SHIFT discards the operation
      @(negedge clk);
      set_port(1'b0, 32'h0000_0001, 5'd3, 1'b1);
      req_valid = 2'b01;
      @(posedge clk) #1 req_valid = '0;
      chk("abort shift busy", {31'b0, busy}, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort busy", {31'b0, busy}, 0);
      chk("abort resp_valid", {30'b0, resp_valid}, 0);
      chk("abort req_ready", {30'b0, req_ready}, 0);
      chk("abort resp_data", resp_data, 0);
      chk("abort resp_id", {31'b0, resp_id}, 0);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) @(posedge clk) #1 chk("abort no resp", {30'b0, resp_valid}, 0);
      run_op(1'b1, 32'hA5A5_0F0F, 5'd12, 1'b1, 32'h50F0_FA5A);

      // full sweep against the bit-wise reference model
      for (int a = 0; a < 32; a++)
         for (int dir = 0; dir < 2; dir++) begin
            logic [31:0] d;
            d = $urandom;
            run_op(1'(a % 2), d, 5'(a), 1'(dir), rot_ref(d, a, 1'(dir)));
         end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
